// File: rtl/siso_pkg.sv
// siso_pkg: shared state encoding, default sizes and counter width for the SISO sequencer
package siso_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    function automatic int cnt_w(input int width, input int depth);
        return $clog2(width + depth + 1);
    endfunction
endpackage

// File: rtl/siso_cnt.sv
// siso_cnt: transfer cycle counter with phase-end and receive-window compares
// ports: clk, rst (async active-low), clr (load zero), inc (count up),
//        shift_last (last SHIFT cycle), flush_last (last FLUSH cycle), rx_win (cnt >= DEPTH)
module siso_cnt
    import siso_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic shift_last,
    output logic flush_last,
    output logic rx_win
);
    localparam int CW = cnt_w(WIDTH, DEPTH);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + CW'(1);
    end
    assign shift_last = cnt == CW'(WIDTH - 1);
    assign flush_last = cnt == CW'(WIDTH + DEPTH - 1);
    assign rx_win     = cnt >= CW'(DEPTH);
endmodule

// File: rtl/siso_seq_ctrl.sv
// siso_seq_ctrl: serialises a word through an external SISO chain and recovers it from the chain output
// ports: clk, rst (async active-low), start/din (request + word), sdi (chain q), sdo (chain d),
//        shift_en (chain enable), busy, done (1-cycle pulse), dout (recovered word)
module siso_seq_ctrl
    import siso_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             sdi,
    output logic             sdo,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);
    state_t state, nxt;
    logic [WIDTH-1:0] tx, rx;
    logic ld, run, shift_last, flush_last, rx_win;

    siso_cnt #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(ld),
        .inc(run),
        .shift_last(shift_last),
        .flush_last(flush_last),
        .rx_win(rx_win)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt      = state;
        ld       = 1'b0;
        case (state)
            IDLE:  begin
                ld  = start;
                nxt = start ? SHIFT : IDLE;
            end
            SHIFT: nxt = shift_last ? FLUSH : SHIFT;
            FLUSH: nxt = flush_last ? DONE : FLUSH;
            DONE:  nxt = IDLE;
        endcase
        run      = state == SHIFT || state == FLUSH;
        shift_en = run;
        busy     = run;
        done     = state == DONE;
        sdo      = state == SHIFT && tx[WIDTH-1];
    end

    // The chain delays each bit by DEPTH enabled cycles, so the first returned
    // bit appears once cnt reaches DEPTH; the final capture lands directly in dout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx   <= '0;
            rx   <= '0;
            dout <= '0;
        end else begin
            if (ld) tx <= din;
            else if (state == SHIFT) tx <= {tx[WIDTH-2:0], 1'b0};
            if (run && rx_win) rx <= {rx[WIDTH-2:0], sdi};
            if (state == FLUSH && flush_last) dout <= {rx[WIDTH-2:0], sdi};
        end
    end
endmodule

// File: tb/tb_siso_seq_ctrl.sv
// tb_siso_seq_ctrl: randomized and directed checks of the SISO sequencer against a 4-stage chain model
module tb_siso_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] din = '0;
    logic       sdi, sdo, shift_en, busy, done;
    logic [7:0] dout;
    logic       stuck = 1'b0;
    logic [3:0] chain = '0;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] obs_sdo, dout_done;
    int flush_nz, idle_nz, busy_cnt, busy_first, done_cnt, done_at;

    siso_seq_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .din(din),
        .sdi(sdi),
        .sdo(sdo),
        .shift_en(shift_en),
        .busy(busy),
        .done(done),
        .dout(dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (shift_en) chain <= {chain[2:0], sdo};
    assign sdi = stuck ? 1'b1 : chain[3];

    // Runs one transfer of d and records what the chain side saw; optionally
    // pulses start again with d2 at observation cycle ovl.
    task automatic xfer(input logic [7:0] d, input int ovl, input logic [7:0] d2);
        @(negedge clk);
        start = 1'b1;
        din = d;
        obs_sdo = '0;
        flush_nz = 0;
        idle_nz = 0;
        busy_cnt = 0;
        busy_first = -1;
        done_cnt = 0;
        done_at = -1;
        dout_done = 'x;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            start = (c == ovl);
            din = (c == ovl) ? d2 : d;
            if (busy) begin
                if (busy_first < 0) busy_first = c;
                if (busy_cnt < 8) obs_sdo = {obs_sdo[6:0], sdo};
                else flush_nz += int'(sdo);
                busy_cnt++;
            end else idle_nz += int'(sdo);
            if (done) begin
                done_cnt++;
                done_at = c;
                dout_done = dout;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({sdo, shift_en, busy, done, dout} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sdo=%b en=%b busy=%b done=%b dout=%h, want all 0", sdo, shift_en, busy, done, dout);
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_loopback();
        xfer(8'hA5, -1, 8'h00);
        n_checks++;
        if (obs_sdo !== 8'hA5) begin n_fail++; $display("FAIL loop_sdo: got %h want a5", obs_sdo); end
        n_checks++;
        if (busy_first !== 0 || busy_cnt !== 12) begin n_fail++; $display("FAIL loop_busy: first=%0d cycles=%0d want 0/12", busy_first, busy_cnt); end
        n_checks++;
        if (done_cnt !== 1 || done_at !== 12) begin n_fail++; $display("FAIL loop_done: count=%0d at=%0d want 1/12", done_cnt, done_at); end
        n_checks++;
        if (dout_done !== 8'hA5 || dout !== 8'hA5) begin n_fail++; $display("FAIL loop_dout: got %h/%h want a5", dout_done, dout); end
        n_checks++;
        if (flush_nz !== 0 || idle_nz !== 0) begin n_fail++; $display("FAIL loop_sdo_zero: flush=%0d idle=%0d want 0/0", flush_nz, idle_nz); end
    endtask

    task automatic test_overlap();
        xfer(8'hA5, 3, 8'h3C);
        n_checks++;
        if (obs_sdo !== 8'hA5 || busy_cnt !== 12) begin n_fail++; $display("FAIL ovl_stream: sdo=%h busy=%0d want a5/12", obs_sdo, busy_cnt); end
        n_checks++;
        if (done_cnt !== 1 || dout_done !== 8'hA5) begin n_fail++; $display("FAIL ovl_done: count=%0d dout=%h want 1/a5", done_cnt, dout_done); end
    endtask

    task automatic test_back_to_back();
        int d_at[2];
        logic [7:0] d_val[2];
        int nd = 0;
        d_at = '{-1, -1};
        d_val = '{8'hxx, 8'hxx};
        @(negedge clk);
        start = 1'b1;
        din = 8'hFF;
        for (int c = 0; c < 40 && nd < 2; c++) begin
            @(negedge clk);
            if (c == 2) din = 8'h00;
            if (done) begin
                d_at[nd] = c;
                d_val[nd] = dout;
                nd++;
                if (nd == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks++;
        if (d_val[0] !== 8'hFF) begin n_fail++; $display("FAIL b2b_first: got %h want ff", d_val[0]); end
        n_checks++;
        if (d_val[1] !== 8'h00) begin n_fail++; $display("FAIL b2b_second: got %h want 00", d_val[1]); end
        n_checks++;
        if (d_at[0] !== 12 || d_at[1] !== 26) begin n_fail++; $display("FAIL b2b_timing: done at %0d/%0d want 12/26", d_at[0], d_at[1]); end
        repeat (16) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: busy=%b want 0", busy); end
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        @(negedge clk);
        start = 1'b1;
        din = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({sdo, shift_en, busy, done, dout} !== 12'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got sdo=%b en=%b busy=%b done=%b dout=%h, want all 0", sdo, shift_en, busy, done, dout);
        end
        repeat (20) begin
            @(negedge clk);
            seen += int'(done);
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL midrst_nodone: %0d done pulses want 0", seen); end
        @(posedge clk);
        #1 rst = 1'b1;
        xfer(8'h81, -1, 8'h00);
        n_checks++;
        if (busy_first !== 0 || dout_done !== 8'h81) begin n_fail++; $display("FAIL midrst_after: first=%0d dout=%h want 0/81", busy_first, dout_done); end
    endtask

    task automatic test_stuck();
        stuck = 1'b1;
        xfer(8'h00, -1, 8'h00);
        stuck = 1'b0;
        n_checks++;
        if (dout_done !== 8'hFF || busy_cnt !== 12) begin n_fail++; $display("FAIL stuck_dout: dout=%h busy=%0d want ff/12", dout_done, busy_cnt); end
        n_checks++;
        if (obs_sdo !== 8'h00 || flush_nz !== 0 || idle_nz !== 0) begin n_fail++; $display("FAIL stuck_sdo: sdo=%h flush=%0d idle=%0d want 0", obs_sdo, flush_nz, idle_nz); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xfer(d, -1, 8'h00);
            n_checks++;
            if (obs_sdo !== d || flush_nz !== 0) begin n_fail++; $display("FAIL rand_sdo[%0d]: got %h flush=%0d want %h/0", i, obs_sdo, flush_nz, d); end
            n_checks++;
            if (done_cnt !== 1 || done_at !== 12 || dout_done !== d) begin
                n_fail++;
                $display("FAIL rand_dout[%0d]: count=%0d at=%0d dout=%h want 1/12/%h", i, done_cnt, done_at, dout_done, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_overlap();
        test_back_to_back();
        test_mid_reset();
        test_stuck();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
